// File: rtl/if_id_buf.sv
// ---------------------------------------------------------------------------
// if_id_buf: fetch-to-decode decoupling buffer.
//
// A 2-entry skid FIFO carrying the fetch bundle (PC, instruction, trap bits,
// branch-prediction tag) from ifu to idu. in_ready_o depends only on
// registered occupancy, so a decode stall never forms a combinational path
// back into fetch/icache timing. flush_i discards everything held.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds its payload stable
// while valid is high and ready is low. ready never depends on valid.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush_i             drop all held entries (redirect)
//   in_valid_i/in_ready_o and in_*_i    fetch-side bundle stream
//   out_valid_o/out_ready_i and out_*_o decode-side head of the FIFO
//   perf_bubble_o, perf_flush_o         only with IF_ID_BUF_PERF_EN
//
// Optional feature: define IF_ID_BUF_PERF_EN to add two 32-bit saturating
// performance counters (decode bubbles, flushes of a non-empty buffer).
// ---------------------------------------------------------------------------
module if_id_buf #(
    parameter int          TRAP_LEN = 32,
    parameter int          HISLEN   = 8,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         in_pc_i,
    input  logic [31:0]         in_inst_i,
    input  logic [TRAP_LEN-1:0] in_trap_i,
    input  logic                in_pdt_res_i,
    input  logic [31:0]         in_pdt_pc_i,
    input  logic [HISLEN-1:0]   in_history_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_pc_o,
    output logic [31:0]         out_inst_o,
    output logic [TRAP_LEN-1:0] out_trap_o,
    output logic                out_pdt_res_o,
    output logic [31:0]         out_pdt_pc_o,
`ifdef IF_ID_BUF_PERF_EN
    output logic [HISLEN-1:0]   out_history_o,
    output logic [31:0]         perf_bubble_o,
    output logic [31:0]         perf_flush_o
`else
    output logic [HISLEN-1:0]   out_history_o
`endif
);

    // State value equals the number of occupied entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   rd_ptr_q, rd_ptr_d;
    logic   wr_ptr_q, wr_ptr_d;
    logic   enq, deq;

    // Entry storage; data is not reset, validity comes from state_q.
    logic [31:0]         pc_mem_q     [2];
    logic [31:0]         inst_mem_q   [2];
    logic [TRAP_LEN-1:0] trap_mem_q   [2];
    logic                pdt_res_mem_q[2];
    logic [31:0]         pdt_pc_mem_q [2];
    logic [HISLEN-1:0]   hist_mem_q   [2];

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign enq         = in_valid_i & in_ready_o;
    assign deq         = out_valid_o & out_ready_i;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_i) begin
            // Flush wins: same-cycle enq is dropped, deq needs no bookkeeping.
            state_d  = EMPTY;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (enq) wr_ptr_d = ~wr_ptr_q;
            if (deq) rd_ptr_d = ~rd_ptr_q;
            case (state_q)
                EMPTY:   if (enq) state_d = ONE;
                ONE: begin
                    if (enq && !deq)      state_d = FULL;
                    else if (!enq && deq) state_d = EMPTY;
                end
                FULL:    if (deq) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !flush_i) begin
            pc_mem_q[wr_ptr_q]      <= in_pc_i;
            inst_mem_q[wr_ptr_q]    <= in_inst_i;
            trap_mem_q[wr_ptr_q]    <= in_trap_i;
            pdt_res_mem_q[wr_ptr_q] <= in_pdt_res_i;
            pdt_pc_mem_q[wr_ptr_q]  <= in_pdt_pc_i;
            hist_mem_q[wr_ptr_q]    <= in_history_i;
        end
    end

    // Head fields are masked to bubble values whenever the buffer is empty.
    always_comb begin
        out_pc_o      = 32'd0;
        out_inst_o    = NOP_INST;
        out_trap_o    = '0;
        out_pdt_res_o = 1'b0;
        out_pdt_pc_o  = 32'd0;
        out_history_o = '0;
        if (out_valid_o) begin
            out_pc_o      = pc_mem_q[rd_ptr_q];
            out_inst_o    = inst_mem_q[rd_ptr_q];
            out_trap_o    = trap_mem_q[rd_ptr_q];
            out_pdt_res_o = pdt_res_mem_q[rd_ptr_q];
            out_pdt_pc_o  = pdt_pc_mem_q[rd_ptr_q];
            out_history_o = hist_mem_q[rd_ptr_q];
        end
    end

`ifdef IF_ID_BUF_PERF_EN
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubble_q <= 32'd0;
            perf_flush_q  <= 32'd0;
        end else begin
            if (out_ready_i && !out_valid_o && (perf_bubble_q != 32'hFFFF_FFFF))
                perf_bubble_q <= perf_bubble_q + 32'd1;
            if (flush_i && (state_q != EMPTY) && (perf_flush_q != 32'hFFFF_FFFF))
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_bubble_o = perf_bubble_q;
    assign perf_flush_o  = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// ---------------------------------------------------------------------------
// tb_if_id_buf: directed self-checking bench for if_id_buf.
// Inputs change 1 ns after each rising edge; outputs are checked at the same
// point, so every check sees state settled by the preceding edge.
// ---------------------------------------------------------------------------
module tb_if_id_buf;

    localparam int          TRAP_LEN = 32;
    localparam int          HISLEN   = 8;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic                clk;
    logic                rst;
    logic                flush_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [31:0]         in_pc_i;
    logic [31:0]         in_inst_i;
    logic [TRAP_LEN-1:0] in_trap_i;
    logic                in_pdt_res_i;
    logic [31:0]         in_pdt_pc_i;
    logic [HISLEN-1:0]   in_history_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [31:0]         out_pc_o;
    logic [31:0]         out_inst_o;
    logic [TRAP_LEN-1:0] out_trap_o;
    logic                out_pdt_res_o;
    logic [31:0]         out_pdt_pc_o;
    logic [HISLEN-1:0]   out_history_o;

    int n_checks;
    int n_fail;

    if_id_buf #(.TRAP_LEN(TRAP_LEN), .HISLEN(HISLEN), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_pc_i      (in_pc_i),
        .in_inst_i    (in_inst_i),
        .in_trap_i    (in_trap_i),
        .in_pdt_res_i (in_pdt_res_i),
        .in_pdt_pc_i  (in_pdt_pc_i),
        .in_history_i (in_history_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_pc_o     (out_pc_o),
        .out_inst_o   (out_inst_o),
        .out_trap_o   (out_trap_o),
        .out_pdt_res_o(out_pdt_res_o),
        .out_pdt_pc_o (out_pdt_pc_o),
        .out_history_o(out_history_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid_i = v;
        in_pc_i    = pc;
        in_inst_i  = inst;
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        check_eq({tag, "_ready"}, 64'(in_ready_o), 64'd1);
        check_eq({tag, "_inst"},  64'(out_inst_o), 64'(NOP));
        check_eq({tag, "_pc"},    64'(out_pc_o), 64'd0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic rdy);
        check_eq({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        check_eq({tag, "_pc"},    64'(out_pc_o), 64'(pc));
        check_eq({tag, "_ready"}, 64'(in_ready_o), 64'(rdy));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        flush_i      = 1'b0;
        in_valid_i   = 1'b0;
        in_pc_i      = 32'd0;
        in_inst_i    = 32'd0;
        in_trap_i    = '0;
        in_pdt_res_i = 1'b0;
        in_pdt_pc_i  = 32'd0;
        in_history_i = '0;
        out_ready_i  = 1'b0;

        // Reset then idle
        cyc();
        cyc();
        check_bubble("rst");
        check_eq("rst_trap",    64'(out_trap_o), 64'd0);
        check_eq("rst_pdt_res", 64'(out_pdt_res_o), 64'd0);
        check_eq("rst_pdt_pc",  64'(out_pdt_pc_o), 64'd0);
        check_eq("rst_hist",    64'(out_history_o), 64'd0);
        rst = 1'b0;
        cyc();
        check_bubble("idle");

        // Streaming with decode always ready: one-cycle latency, stays ONE
        out_ready_i = 1'b1;
        drive(1'b1, 32'h80000000, 32'h00100093);
        cyc();
        check_head("s0", 32'h80000000, 1'b1);
        check_eq("s0_inst", 64'(out_inst_o), 64'h00100093);
        drive(1'b1, 32'h80000004, 32'h00200113);
        cyc();
        check_head("s1", 32'h80000004, 1'b1);
        check_eq("s1_inst", 64'(out_inst_o), 64'h00200113);
        drive(1'b1, 32'h80000008, 32'h00300193);
        cyc();
        check_head("s2", 32'h80000008, 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        check_bubble("s_drain");

        // Stall: fill to FULL, third bundle refused, drain in order
        out_ready_i = 1'b0;
        drive(1'b1, 32'h80000000, 32'h00100093);
        cyc();
        check_head("f0", 32'h80000000, 1'b1);
        drive(1'b1, 32'h80000004, 32'h00200113);
        cyc();
        check_head("f1", 32'h80000000, 1'b0);
        drive(1'b1, 32'h80000008, 32'h00300193);
        cyc();
        check_head("f2", 32'h80000000, 1'b0);
        drive(1'b0, 32'h0, 32'h0);
        out_ready_i = 1'b1;
        cyc();
        check_head("d0", 32'h80000004, 1'b1);
        check_eq("d0_inst", 64'(out_inst_o), 64'h00200113);
        cyc();
        check_bubble("d1");

        // Flush while FULL with a same-cycle enqueue attempt
        out_ready_i = 1'b0;
        drive(1'b1, 32'h80000000, 32'h00100093);
        cyc();
        drive(1'b1, 32'h80000004, 32'h00200113);
        cyc();
        check_head("pf", 32'h80000000, 1'b0);
        flush_i = 1'b1;
        drive(1'b1, 32'h80000010, 32'h00400213);
        cyc();
        flush_i = 1'b0;
        check_bubble("fl");
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        check_bubble("fl_idle");
        drive(1'b1, 32'h80000020, 32'h00500293);
        cyc();
        check_head("af0", 32'h80000020, 1'b1);
        check_eq("af0_inst", 64'(out_inst_o), 64'h00500293);
        drive(1'b1, 32'h80000024, 32'h00600313);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        out_ready_i = 1'b1;
        cyc();
        check_head("af1", 32'h80000024, 1'b1);
        cyc();
        check_bubble("af_drain");

        // Flush with a same-cycle dequeue from ONE
        out_ready_i = 1'b0;
        drive(1'b1, 32'h80000030, 32'h00700393);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        out_ready_i = 1'b1;
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check_bubble("fd");

        // Full field pass-through
        out_ready_i  = 1'b0;
        drive(1'b1, 32'h80000040, 32'h00000073);
        in_trap_i    = 32'h00001000;
        in_pdt_res_i = 1'b1;
        in_pdt_pc_i  = 32'h80000100;
        in_history_i = 8'hA5;
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        in_trap_i    = '0;
        in_pdt_res_i = 1'b0;
        in_pdt_pc_i  = 32'd0;
        in_history_i = '0;
        check_head("fld", 32'h80000040, 1'b1);
        check_eq("fld_inst",    64'(out_inst_o), 64'h00000073);
        check_eq("fld_trap",    64'(out_trap_o), 64'h00001000);
        check_eq("fld_pdt_res", 64'(out_pdt_res_o), 64'd1);
        check_eq("fld_pdt_pc",  64'(out_pdt_pc_o), 64'h80000100);
        check_eq("fld_hist",    64'(out_history_o), 64'hA5);

        // Asynchronous reset mid-cycle while ONE
        #2;
        rst = 1'b1;
        #1;
        check_bubble("arst");
        check_eq("arst_trap", 64'(out_trap_o), 64'd0);
        check_eq("arst_hist", 64'(out_history_o), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check_bubble("post_rst");

        // Pointers restart cleanly after reset: two entries in order
        drive(1'b1, 32'h80000050, 32'h00800413);
        cyc();
        drive(1'b1, 32'h80000054, 32'h00900493);
        cyc();
        check_head("pr0", 32'h80000050, 1'b0);
        drive(1'b0, 32'h0, 32'h0);
        out_ready_i = 1'b1;
        cyc();
        check_head("pr1", 32'h80000054, 1'b1);
        cyc();
        check_bubble("pr_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
